// File: rtl/button_input_conditioner_if.sv
// Button pin and conditioned-strobe bundle between the alarm-clock controls and the conditioner.
// master drives the raw pins; slave is the conditioner side.
interface button_input_conditioner_if #(
    parameter int NUM_BUTTONS = 4
);
    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] btn_level;
    logic [NUM_BUTTONS-1:0] btn_press;
    logic [NUM_BUTTONS-1:0] btn_release;
    logic [NUM_BUTTONS-1:0] btn_repeat;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/button_input_conditioner.sv
// Per-button synchroniser, debouncer and auto-repeat generator for the alarm-clock controls.
//   state     | meaning
//   IDLE      | button released, waiting for a debounced press
//   HOLD_DLY  | pressed, counting the initial delay before the first repeat
//   REPEATING | held past the delay, emitting a repeat every REPEAT_PERIOD cycles
module button_input_conditioner #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input logic                      clk,
    input logic                      rst,
    button_input_conditioner_if.slave btn
);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_TC  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_TC = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_TC = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_DLY  = 2'd1,
        REPEATING = 2'd2
    } rpt_state_t;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        logic             sync_a;
        logic             sync_b;
        logic [DB_W-1:0]  db_cnt;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             repeat_q;
        logic             db_done;
        logic             press_evt;
        logic             release_evt;
        rpt_state_t       state_q;
        rpt_state_t       state_d;
        logic [RPT_W-1:0] rpt_cnt_q;
        logic [RPT_W-1:0] rpt_cnt_d;
        logic             repeat_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_a <= 1'b0;
                sync_b <= 1'b0;
            end else begin
                sync_a <= btn.btn_raw[i];
                sync_b <= sync_a;
            end
        end

        // Level flips once the synchronised input has disagreed for DEBOUNCE_CYCLES cycles.
        assign db_done     = (sync_b != level_q) && (db_cnt == DB_TC);
        assign press_evt   = db_done && !level_q;
        assign release_evt = db_done && level_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                db_cnt    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= press_evt;
                release_q <= release_evt;
                if ((sync_b == level_q) || db_done) begin
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
                if (db_done) begin
                    level_q <= !level_q;
                end
            end
        end

        always_comb begin
            state_d   = state_q;
            rpt_cnt_d = rpt_cnt_q;
            repeat_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (press_evt) begin
                        state_d   = HOLD_DLY;
                        rpt_cnt_d = '0;
                        repeat_d  = 1'b1;
                    end
                end
                HOLD_DLY: begin
                    if (release_evt) begin
                        state_d   = IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == DLY_TC) begin
                        state_d   = REPEATING;
                        rpt_cnt_d = '0;
                        repeat_d  = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                REPEATING: begin
                    // A release landing on a due repeat suppresses that repeat.
                    if (release_evt) begin
                        state_d   = IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == PER_TC) begin
                        rpt_cnt_d = '0;
                        repeat_d  = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                rpt_cnt_q <= '0;
                repeat_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                rpt_cnt_q <= rpt_cnt_d;
                repeat_q  <= repeat_d;
            end
        end

        assign btn.btn_level[i]   = level_q;
        assign btn.btn_press[i]   = press_q;
        assign btn.btn_release[i] = release_q;
        assign btn.btn_repeat[i]  = repeat_q;
    end
endmodule

// File: tb/tb_button_input_conditioner.sv
// Randomised and directed bench for button_input_conditioner against an event-level reference model.
module tb_button_input_conditioner;
    localparam int NB = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int HMAX = 4096;

    logic clk;
    logic rst;

    button_input_conditioner_if #(.NUM_BUTTONS(NB)) ifc ();

    button_input_conditioner #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // reference model: pin delay line, run length of disagreement, time since press
    int m_s1[NB], m_s2[NB], m_lvl[NB], m_run[NB], m_held[NB], m_pt[NB];
    logic [NB-1:0] e_level, e_press, e_rel, e_rep;
    int edge_no = 0;

    logic [NB-1:0] h_level[HMAX], h_press[HMAX], h_rel[HMAX], h_rep[HMAX];
    int n_press[NB], n_rel[NB], n_rep[NB], n_lvl[NB], first_press[NB];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", tag, edge_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_held[i] = 0; m_pt[i] = 0;
        end
        e_level = '0; e_press = '0; e_rel = '0; e_rep = '0;
    endtask

    task automatic model_step(input logic [NB-1:0] raw);
        int seen, d;
        e_press = '0; e_rel = '0; e_rep = '0;
        for (int i = 0; i < NB; i++) begin
            seen = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(raw[i]);
            m_run[i] = (seen != m_lvl[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == DB) begin
                m_lvl[i] = 1 - m_lvl[i];
                m_run[i] = 0;
                if (m_lvl[i] == 1) e_press[i] = 1'b1;
                else               e_rel[i]   = 1'b1;
            end
            if (e_press[i]) begin
                m_held[i] = 1;
                m_pt[i]   = edge_no;
                e_rep[i]  = 1'b1;
            end else if (e_rel[i]) begin
                m_held[i] = 0;
            end else if (m_held[i] == 1) begin
                d = edge_no - m_pt[i];
                e_rep[i] = (d >= RD) && (((d - RD) % RP) == 0);
            end
            e_level[i] = (m_lvl[i] == 1);
        end
    endtask

    task automatic clear_tallies();
        for (int i = 0; i < NB; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_rep[i] = 0; n_lvl[i] = 0; first_press[i] = -1;
        end
    endtask

    task automatic step(input logic [NB-1:0] nxt, input logic rst_nxt);
        @(posedge clk);
        edge_no++;
        if (rst) model_reset();
        else     model_step(ifc.btn_raw);
        #1;
        rst = rst_nxt;
        ifc.btn_raw = nxt;
        if (rst) model_reset();
        @(negedge clk);
        check_eq("level",   ifc.btn_level,   e_level);
        check_eq("press",   ifc.btn_press,   e_press);
        check_eq("release", ifc.btn_release, e_rel);
        check_eq("repeat",  ifc.btn_repeat,  e_rep);
        if (edge_no < HMAX) begin
            h_level[edge_no] = ifc.btn_level;
            h_press[edge_no] = ifc.btn_press;
            h_rel[edge_no]   = ifc.btn_release;
            h_rep[edge_no]   = ifc.btn_repeat;
        end
        for (int i = 0; i < NB; i++) begin
            if (ifc.btn_press[i]) begin
                n_press[i]++;
                if (first_press[i] < 0) first_press[i] = edge_no;
            end
            if (ifc.btn_release[i]) n_rel[i]++;
            if (ifc.btn_repeat[i])  n_rep[i]++;
            if (ifc.btn_level[i])   n_lvl[i]++;
        end
    endtask

    task automatic hold(input logic [NB-1:0] v, input int n);
        for (int k = 0; k < n; k++) step(v, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {ifc.btn_level, ifc.btn_press, ifc.btn_release, ifc.btn_repeat}, '0);
    endtask

    initial begin
        int a, b, rf;
        logic [NB-1:0] rnd;
        ifc.btn_raw = '0;
        rst = 1'b0;
        model_reset();
        clear_tallies();
        #1 rst = 1'b1;
        #1 check_all_zero("reset_outputs");
        step('0, 1'b1);
        step('0, 1'b1);
        step('0, 1'b0);
        hold('0, 3);

        // single press on channel 0
        clear_tallies();
        step(4'b0001, 1'b0);
        a = edge_no;
        hold(4'b0001, 8);
        check_eq("t1_press_edge", first_press[0], a + 6);
        check_eq("t1_press_vec",  h_press[a + 6], 4'b0001);
        check_eq("t1_rep_vec",    h_rep[a + 6],   4'b0001);
        check_eq("t1_level_pre",  h_level[a + 5], 4'b0000);
        hold('0, 14);

        // short glitch on channel 1
        clear_tallies();
        hold(4'b0010, 3);
        hold('0, 12);
        check_eq("t2_activity", n_press[1] + n_rel[1] + n_rep[1] + n_lvl[1], 0);

        // long hold on channel 2, released so the debounced release meets a due repeat
        clear_tallies();
        step(4'b0100, 1'b0);
        a = edge_no;
        hold(4'b0100, 39);
        hold('0, 12);
        check_eq("t3_press_cnt", n_press[2], 1);
        check_eq("t3_rep_cnt",   n_rep[2], 11);
        check_eq("t3_rep_p",     h_rep[a + 6][2], 1'b1);
        check_eq("t3_rep_p9",    h_rep[a + 15][2], 1'b0);
        check_eq("t3_rep_p10",   h_rep[a + 16][2], 1'b1);
        check_eq("t3_rep_p11",   h_rep[a + 17][2], 1'b0);
        check_eq("t3_rep_p13",   h_rep[a + 19][2], 1'b1);
        check_eq("t4_release",   h_rel[a + 46], 4'b0100);
        check_eq("t4_no_repeat", h_rep[a + 46], 4'b0000);
        check_eq("t4_level",     h_level[a + 46], 4'b0000);

        // simultaneous presses, independent release
        clear_tallies();
        step(4'b1010, 1'b0);
        a = edge_no;
        hold(4'b1010, 14);
        step(4'b0010, 1'b0);
        b = edge_no;
        hold(4'b0010, 10);
        check_eq("t5_press_vec", h_press[a + 6], 4'b1010);
        check_eq("t5_rel_vec",   h_rel[b + 6],   4'b1000);
        check_eq("t5_level_vec", h_level[b + 6], 4'b0010);
        hold('0, 12);

        // reset while channel 0 is repeating
        clear_tallies();
        step(4'b0001, 1'b0);
        a = edge_no;
        hold(4'b0001, 19);
        check_eq("t6_rep_before", h_rep[a + 19], 4'b0001);
        rst = 1'b1;
        model_reset();
        #1 check_all_zero("t6_async_clear");
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        clear_tallies();
        step(4'b0001, 1'b0);
        rf = edge_no;
        hold(4'b0001, 8);
        check_eq("t6_repress_edge", first_press[0], rf + 6);
        hold('0, 12);

        // random pin activity
        rnd = '0;
        for (int k = 0; k < 900; k++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 11) == 0) rnd[i] = ~rnd[i];
            end
            step(rnd, 1'b0);
        end
        hold('0, 15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
